// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the mem_ctrl instruction/data memory sharer.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    FLAST,
    FRESP,
    DRD,
    DCAP,
    DRESP,
    DWR
  } mem_ctrl_state_t;

  typedef enum logic {GNT_IF, GNT_D} gnt_t;

  localparam int FETCH_BEATS = 4;
  localparam int INSTR_W     = 32;

endpackage

// File: rtl/mem_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, last-grant flop
// updated only when the granted request is actually accepted.
module rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_if,
  input  logic req_d,
  input  logic update,
  output logic gnt_if,
  output logic gnt_d
);

  gnt_t last_gnt;

  // Fetch wins when alone, or when contended and data was served last.
  always_comb begin
    gnt_if = req_if && (!req_d || (last_gnt == GNT_D));
    gnt_d  = req_d && !gnt_if;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt <= GNT_D;
    end else if (update) begin
      last_gnt <= gnt_if ? GNT_IF : GNT_D;
    end
  end

endmodule

// File: rtl/mem_ctrl.sv
// Shares one byte-wide single-port memory between a 4-beat instruction fetch
// port and a byte data port. Optional: MEM_CTRL_WRITE_PROTECT_EN rejects low writes.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] WP_LIMIT = 'h80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [7:0]         d_wdata,
  output logic               d_ready,
  output logic               d_rvalid,
  output logic [7:0]         d_rdata,
  output logic               d_err,
  output logic [ADDR_W-1:0]  address,
  output logic [7:0]         data_in,
  output logic               rw_select,
  input  logic [7:0]         data_out
);

`ifdef MEM_CTRL_WRITE_PROTECT_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  mem_ctrl_state_t   state, state_n;
  logic [1:0]        beat;
  logic [INSTR_W-9:0] instr_buf;
  logic              err_q;
  logic              gnt_if, gnt_d, wr_blocked;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req_if (if_req),
    .req_d  (d_req),
    .update (if_ready || d_ready),
    .gnt_if (gnt_if),
    .gnt_d  (gnt_d)
  );

  assign wr_blocked = WP_EN && d_we && (d_addr < WP_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A rejected write runs the read path so its error pulse lands in cycle 3.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (if_ready)     state_n = FETCH;
        else if (d_ready) state_n = (d_we && !wr_blocked) ? DWR : DRD;
      end
      FETCH:   if (beat == 2'(FETCH_BEATS - 1)) state_n = FLAST;
      FLAST:   state_n = FRESP;
      FRESP:   state_n = IDLE;
      DRD:     state_n = DCAP;
      DCAP:    state_n = DRESP;
      DRESP:   state_n = IDLE;
      DWR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    if_ready  = !rst && (state == IDLE) && gnt_if;
    d_ready   = !rst && (state == IDLE) && gnt_d;
    if_valid  = (state == FRESP);
    d_rvalid  = (state == DRESP) && !err_q;
    rw_select = (state == DWR) && !rst;
  end

`ifdef MEM_CTRL_WRITE_PROTECT_EN
  assign d_err = (state == DRESP) && err_q;
`else
  assign d_err = 1'b0;
`endif

  // Byte k-1 arrives during beat k; the last byte lands in FLAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      address   <= '0;
      data_in   <= '0;
      beat      <= '0;
      instr_buf <= '0;
      if_instr  <= '0;
      d_rdata   <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat <= '0;
          if (if_ready) begin
            address <= if_addr;
          end else if (d_ready) begin
            address <= d_addr;
            err_q   <= wr_blocked;
            if (d_we && !wr_blocked) data_in <= d_wdata;
          end
        end
        FETCH: begin
          beat <= beat + 2'd1;
          if (beat != 2'(FETCH_BEATS - 1)) address <= address + ADDR_W'(1);
          if (beat != 2'd0) instr_buf <= {instr_buf[INSTR_W-17:0], data_out};
        end
        FLAST:   if_instr <= {instr_buf, data_out};
        DCAP:    if (!err_q) d_rdata <= data_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: drivers push expected responses, a negedge
// monitor pops and compares them against the DUT response pulses.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ready, if_valid;
  logic [7:0]  if_addr;
  logic [31:0] if_instr;
  logic        d_req, d_we, d_ready, d_rvalid, d_err;
  logic [7:0]  d_addr, d_wdata, d_rdata;
  logic [7:0]  address, data_in, data_out;
  logic        rw_select;

  mem_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_valid(if_valid), .if_instr(if_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .address(address), .data_in(data_in), .rw_select(rw_select),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int rw_cnt = 0;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rw_select) mem[address] <= data_in;
    data_out <= mem[address];
  end

  logic [31:0] q_if[$];
  int          q_if_cyc[$];
  logic [7:0]  q_d[$];
  int          q_d_cyc[$];
  int          q_err_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rw_select) rw_cnt++;
    if (if_valid) begin
      if (q_if.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
      else begin
        chk("if_instr", if_instr, q_if.pop_front());
        chk("if_valid_cycle", 32'(cyc), 32'(q_if_cyc.pop_front()));
      end
    end
    if (d_rvalid) begin
      if (q_d.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
      else begin
        chk("d_rdata", 32'(d_rdata), 32'(q_d.pop_front()));
        chk("d_rvalid_cycle", 32'(cyc), 32'(q_d_cyc.pop_front()));
      end
    end
    if (d_err) begin
      if (q_err_cyc.size() == 0) chk("d_err_unexpected", 32'd1, 32'd0);
      else chk("d_err_cycle", 32'(cyc), 32'(q_err_cyc.pop_front()));
    end
  end

  // Called at a negedge; returns in the accept cycle (ready seen high).
  task automatic wait_rdy(input bit is_if, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (is_if ? if_ready : d_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ready_timeout: got no ready expected ready within 20 cycles");
    end
  endtask

  task automatic do_fetch(input logic [7:0] a, input logic [31:0] e);
    bit ok;
    int c0;
    logic [7:0] ak;
    @(negedge clk);
    if_req = 1'b1;
    if_addr = a;
    wait_rdy(1'b1, ok);
    c0 = cyc;
    if (ok) begin
      q_if.push_back(e);
      q_if_cyc.push_back(c0 + 6);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if_req = 1'b0;
      ak = a + 8'(k);
      chk("fetch_address", 32'(address), 32'(ak));
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] wd);
    bit ok, prot;
    int c0;
`ifdef MEM_CTRL_WRITE_PROTECT_EN
    prot = (a < 8'h80);
`else
    prot = 1'b0;
`endif
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b1; d_addr = a; d_wdata = wd;
    wait_rdy(1'b0, ok);
    c0 = cyc;
    if (ok && prot) q_err_cyc.push_back(c0 + 3);
    @(negedge clk);
    d_req = 1'b0;
    chk("rw_select_c1", 32'(rw_select), prot ? 32'd0 : 32'd1);
    @(negedge clk);
    chk("rw_select_c2", 32'(rw_select), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] e);
    bit ok;
    int c0;
    @(negedge clk);
    d_req = 1'b1; d_we = 1'b0; d_addr = a;
    wait_rdy(1'b0, ok);
    c0 = cyc;
    if (ok) begin
      q_d.push_back(e);
      q_d_cyc.push_back(c0 + 3);
    end
    @(negedge clk);
    d_req = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // Both requests pending at a negedge; records grant order (0 = fetch, 1 = data).
  int order[$];
  task automatic contend(input logic [7:0] fa, input logic [31:0] fe,
                         input logic [7:0] da, input logic [7:0] de);
    bit di = 1'b0, dd = 1'b0;
    if_req = 1'b1; if_addr = fa;
    d_req = 1'b1; d_we = 1'b0; d_addr = da;
    for (int n = 0; n < 40 && !(di && dd); n++) begin
      #1;
      chk("one_ready_at_a_time", 32'(if_ready && d_ready), 32'd0);
      if (if_ready && !di) begin
        order.push_back(0);
        q_if.push_back(fe); q_if_cyc.push_back(cyc + 6);
        di = 1'b1;
      end else if (d_ready && !dd) begin
        order.push_back(1);
        q_d.push_back(de); q_d_cyc.push_back(cyc + 3);
        dd = 1'b1;
      end
      @(posedge clk); #1;
      if (di) if_req = 1'b0;
      if (dd) d_req = 1'b0;
      @(negedge clk);
    end
    chk("contend_done", 32'(di && dd), 32'd1);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int exp_rw;
    logic [7:0] exp10;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'hDE; mem[8'h01] = 8'hAD; mem[8'h02] = 8'hBE; mem[8'h03] = 8'hEF;
    mem[8'h04] = 8'h12; mem[8'h05] = 8'h34; mem[8'h06] = 8'h56; mem[8'h07] = 8'h78;
    mem[8'hFE] = 8'hCA; mem[8'hFF] = 8'hFE; mem[8'h10] = 8'h3C;
    data_out = 8'h00;
    rst = 1'b1;
    if_req = 1'b1; if_addr = 8'h04;
    d_req = 1'b1; d_we = 1'b0; d_addr = 8'h01; d_wdata = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_d_ready", 32'(d_ready), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_rw_select", 32'(rw_select), 32'd0);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("rst_d_rdata", 32'(d_rdata), 32'd0);
    chk("rst_d_err", 32'(d_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    contend(8'h04, 32'h12345678, 8'h01, 8'hAD);
    contend(8'h00, 32'hDEADBEEF, 8'h02, 8'hBE);
    chk("grant_count", 32'(order.size()), 32'd4);
    if (order.size() == 4) begin
      chk("grant0_fetch", 32'(order[0]), 32'd0);
      chk("grant1_data", 32'(order[1]), 32'd1);
      chk("grant2_fetch", 32'(order[2]), 32'd0);
      chk("grant3_data", 32'(order[3]), 32'd1);
    end

    do_fetch(8'h00, 32'hDEADBEEF);
    do_write(8'h90, 8'hA5);
    do_read(8'h90, 8'hA5);
    do_fetch(8'hFE, 32'hCAFEDEAD);

`ifdef MEM_CTRL_WRITE_PROTECT_EN
    exp10 = 8'h3C;
    exp_rw = 1;
`else
    exp10 = 8'h55;
    exp_rw = 2;
`endif
    do_write(8'h10, 8'h55);
    do_read(8'h10, exp10);

    // Reset during beat 2 of a fetch: no response, outputs back to reset values.
    @(negedge clk);
    if_req = 1'b1; if_addr = 8'h00;
    #1;
    chk("midrst_ready", 32'(if_ready), 32'd1);
    @(negedge clk); if_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_beat2_addr", 32'(address), 32'h02);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_address", 32'(address), 32'd0);
    chk("midrst_data_in", 32'(data_in), 32'd0);
    chk("midrst_if_instr", if_instr, 32'd0);
    chk("midrst_d_rdata", 32'(d_rdata), 32'd0);
    chk("midrst_rw_select", 32'(rw_select), 32'd0);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    do_fetch(8'h00, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    chk("rw_select_cycles", 32'(rw_cnt), 32'(exp_rw));
    chk("if_queue_drained", 32'(q_if.size()), 32'd0);
    chk("d_queue_drained", 32'(q_d.size()), 32'd0);
    chk("err_queue_drained", 32'(q_err_cyc.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
